// File: rtl/sdram_access_arbiter_pkg.sv
// Shared widths, FSM state type and requester indices for the SDRAM access arbiter.
package sdram_arb_pkg;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam logic [1:0] REQ_RECORD = 2'd0;
    localparam logic [1:0] REQ_PLAY   = 2'd1;
    localparam logic [1:0] REQ_LOAD   = 2'd2;

endpackage

// File: rtl/sdram_access_arbiter_if.sv
// Requester-side and SDRAM-side bus of the arbiter; master is the arbiter itself.
interface sdram_access_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]             req_read;
    logic [NUM_REQ-1:0]             req_write;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_writedata;
    logic [DATA_W-1:0]              req_readdata;
    logic [NUM_REQ-1:0]             req_finished;

    logic                           sdram_read;
    logic                           sdram_write;
    logic [ADDR_W-1:0]              sdram_addr;
    logic [DATA_W-1:0]              sdram_writedata;
    logic [DATA_W-1:0]              sdram_readdata;
    logic                           sdram_finished;

    modport master (
        input  req_read, req_write, req_addr, req_writedata,
        input  sdram_readdata, sdram_finished,
        output req_readdata, req_finished,
        output sdram_read, sdram_write, sdram_addr, sdram_writedata
    );

    modport slave (
        output req_read, req_write, req_addr, req_writedata,
        output sdram_readdata, sdram_finished,
        input  req_readdata, req_finished,
        input  sdram_read, sdram_write, sdram_addr, sdram_writedata
    );
endinterface

// File: rtl/sdram_access_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_i (wrapping) wins.
module rr_picker #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         last_i,
    output logic [1:0]         idx_o,
    output logic               valid_o
);
    logic [1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = 2'((int'(last_i) + off) % NUM_REQ);
            if (req_i[cand]) begin
                idx_o   = cand;
                valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sdram_access_arbiter.sv
// Arbitrates NUM_REQ requesters onto one SDRAM controller port with a BUSY watchdog.
// Define SDRAM_ARB_RECORD_PRIORITY_EN to give requester 0 fixed priority over the rest.
module sdram_access_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    sdram_access_arbiter_if.master bus,
    output logic [1:0]             o_grant_id,
    output logic                   o_busy,
    output logic                   o_timeout
);
    localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [1:0]      PTR_RST = 2'(NUM_REQ - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    arb_state_t          state_q, state_d;
    logic [1:0]          id_q, id_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NUM_REQ-1:0]  fin_q, fin_d;
    logic                timeout_q, timeout_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [1:0]          ptr_q, ptr_d;

    logic [NUM_REQ-1:0]  req_any;
    logic [NUM_REQ-1:0]  pick_req;
    logic [1:0]          pick_idx;
    logic                pick_valid;
    logic [1:0]          win_idx;
    logic                win_valid;
    logic                ptr_take;
    logic [NUM_REQ-1:0]  fin_hit;

    assign req_any = bus.req_read | bus.req_write;

`ifdef SDRAM_ARB_RECORD_PRIORITY_EN
    // Record bypasses the rotation; the pointer only tracks grants among the others.
    assign pick_req  = {req_any[NUM_REQ-1:1], 1'b0};
    assign win_valid = req_any[REQ_RECORD] | pick_valid;
    assign win_idx   = req_any[REQ_RECORD] ? REQ_RECORD : pick_idx;
    assign ptr_take  = (win_idx != REQ_RECORD);
`else
    assign pick_req  = req_any;
    assign win_valid = pick_valid;
    assign win_idx   = pick_idx;
    assign ptr_take  = 1'b1;
`endif

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_i   (pick_req),
        .last_i  (ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_fin
            assign fin_hit[gi] = (id_q == 2'(gi));
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        fin_d     = '0;
        timeout_d = 1'b0;
        wd_d      = wd_q;
        ptr_d     = ptr_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = BUSY;
                    id_d    = win_idx;
                    write_d = bus.req_write[win_idx];
                    addr_d  = bus.req_addr[win_idx];
                    wdata_d = bus.req_writedata[win_idx];
                    wd_d    = '0;
                    if (ptr_take) ptr_d = win_idx;
                end
            end
            BUSY: begin
                // A completion in the last allowed cycle still counts as a completion.
                if (bus.sdram_finished) begin
                    if (!write_q) rdata_d = bus.sdram_readdata;
                    fin_d   = fin_hit;
                    state_d = RELEASE;
                end else if (wd_q == WD_LAST) begin
                    fin_d     = fin_hit;
                    timeout_d = 1'b1;
                    state_d   = RELEASE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            id_q      <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            fin_q     <= '0;
            timeout_q <= 1'b0;
            wd_q      <= '0;
            ptr_q     <= PTR_RST;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            fin_q     <= fin_d;
            timeout_q <= timeout_d;
            wd_q      <= wd_d;
            ptr_q     <= ptr_d;
        end
    end

    // Strobes decode straight from the state so an async reset kills them at once.
    assign bus.sdram_read      = (state_q == BUSY) && !write_q;
    assign bus.sdram_write     = (state_q == BUSY) && write_q;
    assign bus.sdram_addr      = addr_q;
    assign bus.sdram_writedata = wdata_q;
    assign bus.req_readdata    = rdata_q;
    assign bus.req_finished    = fin_q;

    assign o_grant_id = id_q;
    assign o_busy     = (state_q != IDLE);
    assign o_timeout  = timeout_q;
endmodule

// File: doc/sdram_access_arbiter.md
SDRAM_ACCESS_ARBITER -- requirements
Module: sdram_access_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of requesters (0 record, 1 playback, 2 loader); legal range 2..4.
REQ-002 Parameter TIMEOUT_CYC, default 1023, maximum BUSY cycles allowed before abort.
REQ-003 i_clk  in  1  clock.
REQ-004 i_rst  in  1  reset, asynchronous, active-high.
REQ-005 req_read  in  NUM_REQ  per-requester read request, held until that requester's req_finished.
REQ-006 req_write  in  NUM_REQ  per-requester write request, same hold rule.
REQ-007 req_addr  in  NUM_REQ x 23  per-requester word address.
REQ-008 req_writedata  in  NUM_REQ x 32  per-requester write data.
REQ-009 req_readdata  out  32  registered read data, shared by all requesters.
REQ-010 req_finished  out  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-011 sdram_read / sdram_write  out  1 each  strobes to the SDRAM controller.
REQ-012 sdram_addr  out  23 and sdram_writedata  out  32  latched transaction fields.
REQ-013 sdram_readdata  in  32 and sdram_finished  in  1  SDRAM completion handshake.
REQ-014 o_grant_id  out  2  index of the current or last granted requester.
REQ-015 o_busy  out  1  high outside IDLE.
REQ-016 o_timeout  out  1  one-cycle pulse on watchdog abort.

Function
REQ-017 FSM states: IDLE, BUSY, RELEASE.
REQ-018 IDLE: if any requester has read|write, select a winner, latch id/op/addr/data, and enter BUSY on the next edge.
REQ-019 Default arbitration: round-robin; search starts at (last granted + 1) mod NUM_REQ.
REQ-020 Read and write both asserted by one requester: the write is performed and the read is ignored for that grant.
REQ-021 BUSY: drive sdram_read or sdram_write plus latched addr/data continuously; requester inputs are not re-sampled.
REQ-022 sdram_finished in BUSY: register sdram_readdata into req_readdata (reads only; writes leave it unchanged), pulse req_finished[id] on the next cycle, enter RELEASE.
REQ-023 Latency: request at cycle t -> strobe at t+1; finished at t+k -> req_finished and valid req_readdata at t+k+1.
REQ-024 RELEASE: exactly one cycle, all strobes low; return to IDLE (no back-to-back grant inside RELEASE).
REQ-025 Requester drops its request during BUSY: the transaction still completes and the finished pulse is still issued.
REQ-026 Watchdog: counter cleared on BUSY entry; when it reaches TIMEOUT_CYC without sdram_finished, drop strobes, pulse o_timeout and req_finished[id], leave req_readdata unchanged, enter RELEASE.
REQ-027 Round-robin pointer updates on every grant, including timed-out grants.
REQ-028 sdram_finished outside BUSY is ignored.

Reset
REQ-029 Asynchronous reset forces: state IDLE, pointer to last = NUM_REQ-1 (so requester 0 wins first), all outputs 0, watchdog 0.
REQ-030 Reset during BUSY drops strobes immediately; no finished pulse is issued for the aborted transaction.

Configuration
REQ-031 Macro SDRAM_ARB_RECORD_PRIORITY_EN defined: fixed priority, with requester 0 winning whenever it requests and the others round-robin among themselves.
REQ-032 Macro SDRAM_ARB_RECORD_PRIORITY_EN undefined: pure round-robin per REQ-019.

Structure
REQ-033 Package sdram_arb_pkg holds ADDR_W=23, DATA_W=32, the arb_state_t enum (IDLE/BUSY/RELEASE) and the requester index constants REQ_RECORD/REQ_PLAY/REQ_LOAD.
REQ-034 One sub-module rr_picker is used: combinational, taking a request vector and pointer and returning the winner index plus a valid flag.

Verification
REQ-035 Single request: requester 1 writes 0xDEADBEEF to 0x000100; SDRAM finished after 3 cycles -> sdram_write high for 3 cycles, req_finished[1] pulses once, req_finished[0] and req_finished[2] stay 0.
REQ-036 Round-robin: all three requesters reading continuously from reset -> grant order 0,1,2,0,1,2; each req_readdata matches the sdram_readdata returned for that grant.
REQ-037 Priority macro defined: requesters 0 and 2 requesting continuously -> requester 0 granted every time; requester 2 is granted only after requester 0 deasserts.
REQ-038 Timeout with TIMEOUT_CYC=8 and sdram_finished never asserted -> strobe drops after 8 cycles, o_timeout and req_finished[id] pulse, next requester is granted.
REQ-039 Async reset asserted mid-BUSY -> strobes low in the same cycle, no finished pulse, first grant after reset goes to requester 0.
REQ-040 Simultaneous req_read and req_write from requester 0 -> only sdram_write asserted, req_readdata unchanged.
